// File: rtl/d_e_reg_pkg.sv
// Shared widths, NOP control value and stage payload for the decode-to-execute register.
package d_e_reg_pkg;

  localparam int unsigned CTRL_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned TNEW_W = 2;
  localparam int unsigned CNT_W  = 16;

  localparam logic [CTRL_W-1:0] NOP_CTRL = CTRL_W'(0);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] ext;
    logic [REG_W-1:0]  a3;
    logic [TNEW_W-1:0] t_new;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } de_stage_t;

  // Saturating decrement of Tnew as the instruction advances one stage.
  function automatic logic [TNEW_W-1:0] t_new_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

endpackage

// File: rtl/de_operand_slot.sv
// One E-stage register operand with late-forward refresh while the stage is held.
module de_operand_slot
  import d_e_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              hold,
  input  logic              bubble,
  input  logic [DATA_W-1:0] d_data,
  input  logic              fwd_en,
  input  logic [DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0] e_data
);

  logic [DATA_W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (hold) begin
      if (fwd_en) data_d = fwd_data;
    end else if (bubble) begin
      data_d = '0;
    end else begin
      data_d = d_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_q <= '0;
    else          data_q <= data_d;
  end

  assign e_data = data_q;

endmodule

// File: rtl/d_e_reg.sv
// Decode-to-execute pipeline register with bubble insertion, hold with late forwarding,
// and a saturating bubble counter.
module d_e_reg
  import d_e_reg_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              bubble,
  input  logic              hold,
  input  logic [DATA_W-1:0] D_pc,
  input  logic [DATA_W-1:0] D_instr,
  input  logic [DATA_W-1:0] D_rs_data,
  input  logic [DATA_W-1:0] D_rt_data,
  input  logic [DATA_W-1:0] D_ext,
  input  logic [REG_W-1:0]  D_a3,
  input  logic [TNEW_W-1:0] D_t_new,
  input  logic [CTRL_W-1:0] D_ctrl,
  input  logic              fwd_rs_en,
  input  logic              fwd_rt_en,
  input  logic [DATA_W-1:0] fwd_rs_data,
  input  logic [DATA_W-1:0] fwd_rt_data,
  output logic [DATA_W-1:0] E_pc,
  output logic [DATA_W-1:0] E_instr,
  output logic [DATA_W-1:0] E_rs_data,
  output logic [DATA_W-1:0] E_rt_data,
  output logic [DATA_W-1:0] E_ext,
  output logic [REG_W-1:0]  E_a3,
  output logic [TNEW_W-1:0] E_t_new,
  output logic [CTRL_W-1:0] E_ctrl,
  output logic              E_valid,
  output logic [TNEW_W-1:0] M_t_new_next,
  output logic [CNT_W-1:0]  bubble_cnt
);

  de_stage_t          stage_d, stage_q;
  logic [CNT_W-1:0]   bubble_cnt_d, bubble_cnt_q;

  // Hold wins over bubble; a bubble keeps the PC so the slot stays traceable.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!hold) begin
      if (bubble) begin
        stage_d.pc    = D_pc;
        stage_d.instr = '0;
        stage_d.ext   = '0;
        stage_d.a3    = '0;
        stage_d.t_new = '0;
        stage_d.ctrl  = NOP_CTRL;
        stage_d.valid = 1'b0;
        if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end else begin
        stage_d.pc    = D_pc;
        stage_d.instr = D_instr;
        stage_d.ext   = D_ext;
        stage_d.a3    = D_a3;
        stage_d.t_new = D_t_new;
        stage_d.ctrl  = D_ctrl;
        stage_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q.pc    <= '0;
      stage_q.instr <= '0;
      stage_q.ext   <= '0;
      stage_q.a3    <= '0;
      stage_q.t_new <= '0;
      stage_q.ctrl  <= NOP_CTRL;
      stage_q.valid <= 1'b0;
      bubble_cnt_q  <= '0;
    end else begin
      stage_q       <= stage_d;
      bubble_cnt_q  <= bubble_cnt_d;
    end
  end

  de_operand_slot u_rs_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (hold),
    .bubble   (bubble),
    .d_data   (D_rs_data),
    .fwd_en   (fwd_rs_en),
    .fwd_data (fwd_rs_data),
    .e_data   (E_rs_data)
  );

  de_operand_slot u_rt_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .hold     (hold),
    .bubble   (bubble),
    .d_data   (D_rt_data),
    .fwd_en   (fwd_rt_en),
    .fwd_data (fwd_rt_data),
    .e_data   (E_rt_data)
  );

  assign E_pc         = stage_q.pc;
  assign E_instr      = stage_q.instr;
  assign E_ext        = stage_q.ext;
  assign E_a3         = stage_q.a3;
  assign E_t_new      = stage_q.t_new;
  assign E_ctrl       = stage_q.ctrl;
  assign E_valid      = stage_q.valid;
  assign bubble_cnt   = bubble_cnt_q;
  assign M_t_new_next = t_new_dec(stage_q.t_new);

endmodule

// File: tb/tb_d_e_reg.sv
// Scoreboard bench for d_e_reg: a reference model predicts E state per edge, tests compare.
module tb_d_e_reg;
  import d_e_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n, bubble, hold;
  logic [31:0] D_pc, D_instr, D_rs_data, D_rt_data, D_ext;
  logic [4:0]  D_a3;
  logic [1:0]  D_t_new;
  logic [23:0] D_ctrl;
  logic        fwd_rs_en, fwd_rt_en;
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext;
  logic [4:0]  E_a3;
  logic [1:0]  E_t_new, M_t_new_next;
  logic [23:0] E_ctrl;
  logic        E_valid;
  logic [15:0] bubble_cnt;

  typedef struct packed {
    logic [31:0] pc, instr, rs, rt, ext;
    logic [4:0]  a3;
    logic [1:0]  t_new;
    logic [23:0] ctrl;
    logic        valid;
    logic [15:0] cnt;
  } obs_t;

  obs_t m;
  obs_t sb[$];
  obs_t got, exp_o;
  int   n_checks = 0;
  int   n_fail   = 0;

  d_e_reg dut (
    .clk(clk), .reset_n(reset_n), .bubble(bubble), .hold(hold),
    .D_pc(D_pc), .D_instr(D_instr), .D_rs_data(D_rs_data), .D_rt_data(D_rt_data),
    .D_ext(D_ext), .D_a3(D_a3), .D_t_new(D_t_new), .D_ctrl(D_ctrl),
    .fwd_rs_en(fwd_rs_en), .fwd_rt_en(fwd_rt_en),
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .E_pc(E_pc), .E_instr(E_instr), .E_rs_data(E_rs_data), .E_rt_data(E_rt_data),
    .E_ext(E_ext), .E_a3(E_a3), .E_t_new(E_t_new), .E_ctrl(E_ctrl), .E_valid(E_valid),
    .M_t_new_next(M_t_new_next), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t s;
    s.pc = E_pc; s.instr = E_instr; s.rs = E_rs_data; s.rt = E_rt_data; s.ext = E_ext;
    s.a3 = E_a3; s.t_new = E_t_new; s.ctrl = E_ctrl; s.valid = E_valid; s.cnt = bubble_cnt;
    return s;
  endfunction

  function automatic obs_t reset_obs();
    obs_t s = '0;
    s.ctrl = 24'h0;
    return s;
  endfunction

  task automatic set_d(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ext, input logic [4:0] a3,
                       input logic [1:0] tn, input logic [23:0] ctrl);
    D_pc = pc; D_instr = instr; D_rs_data = rs; D_rt_data = rt;
    D_ext = ext; D_a3 = a3; D_t_new = tn; D_ctrl = ctrl;
  endtask

  // Predict the next E state from the current inputs, queue it, then take one edge.
  task automatic clock_in();
    obs_t n = m;
    if (hold) begin
      if (fwd_rs_en) n.rs = fwd_rs_data;
      if (fwd_rt_en) n.rt = fwd_rt_data;
    end else if (bubble) begin
      n.pc = D_pc; n.instr = '0; n.rs = '0; n.rt = '0; n.ext = '0;
      n.a3 = '0; n.t_new = '0; n.ctrl = 24'h0; n.valid = 1'b0;
      if (n.cnt != 16'hFFFF) n.cnt = n.cnt + 16'd1;
    end else begin
      n.pc = D_pc; n.instr = D_instr; n.rs = D_rs_data; n.rt = D_rt_data; n.ext = D_ext;
      n.a3 = D_a3; n.t_new = D_t_new; n.ctrl = D_ctrl; n.valid = 1'b1;
    end
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_d(32'h1234, 32'hDEAD_BEEF, 32'h5, 32'h6, 32'h7, 5'd3, 2'd1, 24'hABCDEF);
    clock_in();
    void'(sb.pop_front());
    #2;
    set_d(32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h1, 32'h2, 32'h3, 5'd31, 2'd3, 24'hFFFFFF);
    reset_n = 1'b0;
    #1;
    got = sample();
    n_checks++;
    if (got !== reset_obs()) begin
      n_fail++;
      $display("FAIL reset_async got=%h want=%h", got, reset_obs());
    end
    m = reset_obs();
    sb.delete();
    @(posedge clk); #1;
    n_checks++;
    if (sample() !== reset_obs()) begin
      n_fail++;
      $display("FAIL reset_held got=%h want=%h", sample(), reset_obs());
    end
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_load();
    logic [1:0] tn_list [3] = '{2'd2, 2'd3, 2'd0};
    logic [1:0] mt_list [3] = '{2'd1, 2'd2, 2'd0};
    bubble = 0; hold = 0;
    for (int i = 0; i < 3; i++) begin
      set_d(32'h3000 + 32'(4 * i), 32'h8C88_0004 + 32'(i), 32'hA000_0000 + 32'(i),
            32'hB000_0000 + 32'(i), 32'hFFFF_8000, 5'd8 + 5'(i), tn_list[i], 24'h5A5A50 + 24'(i));
      clock_in();
      exp_o = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL load[%0d] got=%h want=%h", i, got, exp_o);
      end
      n_checks++;
      if (M_t_new_next !== mt_list[i] || E_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL load_tnew[%0d] got=%0d/%b want=%0d/1", i, M_t_new_next, E_valid, mt_list[i]);
      end
    end
  endtask

  task automatic test_bubble();
    bubble = 1; hold = 0;
    for (int i = 0; i < 3; i++) begin
      set_d(32'h3004, 32'h1111_2222 + 32'(i), 32'h33, 32'h44, 32'h55, 5'd9, 2'd2, 24'h123456);
      clock_in();
      exp_o = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL bubble[%0d] got=%h want=%h", i, got, exp_o);
      end
    end
    n_checks++;
    if (bubble_cnt !== 16'd3 || E_pc !== 32'h3004 || E_a3 !== 5'd0 || E_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_cnt got=%0d pc=%h a3=%0d v=%b want=3 3004 0 0",
               bubble_cnt, E_pc, E_a3, E_valid);
    end
    bubble = 0;
  endtask

  task automatic test_hold_fwd();
    set_d(32'h4000, 32'h0000_0020, 32'h11, 32'h66, 32'h8, 5'd4, 2'd1, 24'h000777);
    clock_in();
    void'(sb.pop_front());
    hold = 1; fwd_rs_en = 1; fwd_rs_data = 32'h22;
    for (int i = 0; i < 2; i++) begin
      set_d(32'h5000 + 32'(i), 32'h9999_0000, 32'hEE, 32'hFF, 32'h1, 5'd30, 2'd3, 24'hFEDCBA);
      if (i == 1) begin fwd_rs_en = 0; fwd_rt_en = 1; fwd_rt_data = 32'h77; end
      clock_in();
      exp_o = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp_o) begin
        n_fail++;
        $display("FAIL hold_fwd[%0d] got=%h want=%h", i, got, exp_o);
      end
    end
    n_checks++;
    if (E_rs_data !== 32'h22 || E_rt_data !== 32'h77 || E_pc !== 32'h4000) begin
      n_fail++;
      $display("FAIL hold_fwd_vals got rs=%h rt=%h pc=%h want 22 77 4000", E_rs_data, E_rt_data, E_pc);
    end
    hold = 0; fwd_rs_en = 1; fwd_rt_en = 1; fwd_rs_data = 32'h99; fwd_rt_data = 32'h98;
    set_d(32'h6000, 32'h1, 32'hAB, 32'hCD, 32'h2, 5'd5, 2'd0, 24'h1);
    clock_in();
    exp_o = sb.pop_front();
    got = sample();
    n_checks++;
    if (got !== exp_o || E_rs_data !== 32'hAB) begin
      n_fail++;
      $display("FAIL fwd_ignored got=%h want=%h", got, exp_o);
    end
    fwd_rs_en = 0; fwd_rt_en = 0;
  endtask

  task automatic test_hold_bubble();
    hold = 1; bubble = 1;
    for (int i = 0; i < 2; i++) begin
      set_d(32'h7000, 32'h2, 32'h3, 32'h4, 32'h5, 5'd6, 2'd2, 24'h2);
      clock_in();
      exp_o = sb.pop_front();
      got = sample();
      n_checks++;
      if (got !== exp_o || bubble_cnt !== 16'd3) begin
        n_fail++;
        $display("FAIL hold_bubble[%0d] got=%h want=%h", i, got, exp_o);
      end
    end
    // Reset arriving while held and bubbling drops everything at once.
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (sample() !== reset_obs()) begin
      n_fail++;
      $display("FAIL reset_mid_hold got=%h want=%h", sample(), reset_obs());
    end
    m = reset_obs();
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    hold = 0; bubble = 0;
  endtask

  task automatic test_saturation();
    bubble = 1; hold = 0;
    set_d(32'h8000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 2'd1, 24'h0);
    for (int i = 0; i < 65535; i++) begin
      clock_in();
      void'(sb.pop_front());
    end
    n_checks++;
    if (bubble_cnt !== 16'hFFFF || m.cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_reach got=%h want=ffff", bubble_cnt);
    end
    clock_in();
    exp_o = sb.pop_front();
    got = sample();
    n_checks++;
    if (got !== exp_o || bubble_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_hold got=%h want=%h", got, exp_o);
    end
    bubble = 0;
  endtask

  initial begin
    reset_n = 0; bubble = 0; hold = 0;
    fwd_rs_en = 0; fwd_rt_en = 0; fwd_rs_data = '0; fwd_rt_data = '0;
    set_d('0, '0, '0, '0, '0, '0, '0, '0);
    m = reset_obs();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    test_reset();
    test_load();
    test_bubble();
    test_hold_fwd();
    test_hold_bubble();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
